full_adder_4bit: RTL and testbench

//   Registered ripple-carry adder: sum = a + b + c_in, with carry-out.

---
 rtl/full_adder_pkg.sv | 10 +
 rtl/full_adder_4bit_if.sv | 38 +++
 rtl/full_adder_1bit.sv | 15 +
 rtl/full_adder_4bit.sv | 64 ++++++
 tb/tb_full_adder_4bit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/full_adder_pkg.sv
// Shared width constant and result bundle for the registered ripple adder.
// Optional signed-overflow output is enabled by FULL_ADDER_4BIT_OVF_EN.
package full_adder_pkg;
    localparam int ADD_W = 4;

    typedef struct packed {
        logic             c_out;
        logic [ADD_W-1:0] sum;
    } add_res_t;
endpackage

// File: rtl/full_adder_4bit_if.sv
// Operand/result bundle between an arithmetic unit and the registered adder.
// Carries ovf only when FULL_ADDER_4BIT_OVF_EN is defined.
interface full_adder_4bit_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef FULL_ADDER_4BIT_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in,
        input  out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output out_valid, sum, c_out, ovf
    );
`else
    modport master (
        output in_valid, a, b, c_in,
        input  out_valid, sum, c_out
    );

    modport slave (
        input  in_valid, a, b, c_in,
        output out_valid, sum, c_out
    );
`endif
endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell, chained to form the ripple-carry datapath.
// Purely combinational; no configuration macros.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_4bit.sv
// Registered ripple-carry adder with one-cycle latency and valid flag.
// Define FULL_ADDER_4BIT_OVF_EN to add the registered signed-overflow output.
module full_adder_4bit
    import full_adder_pkg::*;
#(
    parameter int WIDTH = ADD_W
) (
    input logic              clk,
    input logic              rst_n,
    full_adder_4bit_if.slave bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    assign carry[0] = bus.c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    // Result only loads on a valid strobe, so X operands while idle are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q   <= s;
                c_out_q <= carry[WIDTH];
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

`ifdef FULL_ADDER_4BIT_OVF_EN
    logic ovf_q;

    // Two's-complement overflow: carry into the MSB differs from carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_adder_4bit.sv
// Directed and exhaustive checks for the registered 4-bit adder.
// Checks ovf as well when FULL_ADDER_4BIT_OVF_EN is defined.
module tb_full_adder_4bit;
    import full_adder_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    full_adder_4bit_if #(.WIDTH(4)) bus ();

    full_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] ta,
                         input logic [3:0] tb_, input logic tc);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = ta;
        bus.b        = tb_;
        bus.c_in     = tc;
    endtask

    task automatic test_reset();
        add_res_t got;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            got = {bus.c_out, bus.sum};
            vectors++;
            if (got !== 5'h00 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got res=%h v=%b want res=00 v=0",
                         k, got, bus.out_valid);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            vectors++;
            if (bus.ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ovf[%0d]: got %b want 0", k, bus.ovf);
            end
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic       vc [4];
        logic [4:0] er [4];
        logic       eo [4];
        add_res_t   got;
        va = '{4'd3, 4'd6, 4'd15, 4'd0};
        vb = '{4'd4, 4'd9, 4'd15, 4'd0};
        vc = '{1'b1, 1'b1, 1'b1, 1'b0};
        er = '{5'h08, 5'h10, 5'h1f, 5'h00};
        eo = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, va[k], vb[k], vc[k]);
            @(posedge clk);
            #1;
            got = {bus.c_out, bus.sum};
            vectors++;
            if (got !== er[k] || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL directed[%0d]: got res=%h v=%b want res=%h v=1",
                         k, got, bus.out_valid, er[k]);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            vectors++;
            if (bus.ovf !== eo[k]) begin
                miscompares++;
                $display("FAIL directed_ovf[%0d]: got %b want %b",
                         k, bus.ovf, eo[k]);
            end
`else
            if (eo[k] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_hold();
        add_res_t got;
        drive(1'b1, 4'd5, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        got = {bus.c_out, bus.sum};
        vectors++;
        if (got !== 5'h07 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_load: got res=%h v=%b want res=07 v=1",
                     got, bus.out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 4'bxxxx, 4'bxxxx, 1'bx);
            @(posedge clk);
            #1;
            got = {bus.c_out, bus.sum};
            vectors++;
            if (got !== 5'h07 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL hold[%0d]: got res=%h v=%b want res=07 v=0",
                         k, got, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        add_res_t got;
        drive(1'b1, 4'd9, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        got = {bus.c_out, bus.sum};
        vectors++;
        if (got !== 5'h0c || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_load: got res=%h v=%b want res=0c v=1",
                     got, bus.out_valid);
        end
        drive(1'b1, 4'd1, 4'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.c_out, bus.sum};
        vectors++;
        if (got !== 5'h00 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async: got res=%h v=%b want res=00 v=0",
                     got, bus.out_valid);
        end
        @(posedge clk);
        #1;
        got = {bus.c_out, bus.sum};
        vectors++;
        if (got !== 5'h00 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_held: got res=%h v=%b want res=00 v=0",
                     got, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        int         ia;
        int         ib;
        int         ic;
        int         tot;
        int         sa;
        int         sb;
        int         ss;
        logic [4:0] exp_r;
        logic       exp_o;
        add_res_t   got;
        for (int i = 0; i < 512; i++) begin
            ia = (i >> 5) & 15;
            ib = (i >> 1) & 15;
            ic = i & 1;
            drive(1'b1, 4'(ia), 4'(ib), 1'(ic));
            @(posedge clk);
            #1;
            tot   = ia + ib + ic;
            exp_r = 5'(tot);
            sa    = (ia >= 8) ? ia - 16 : ia;
            sb    = (ib >= 8) ? ib - 16 : ib;
            ss    = sa + sb + ic;
            exp_o = (ss > 7) || (ss < -8);
            got   = {bus.c_out, bus.sum};
            vectors++;
            if (got !== exp_r || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep a=%0d b=%0d c=%0d: got res=%h v=%b want res=%h v=1",
                         ia, ib, ic, got, bus.out_valid, exp_r);
            end
`ifdef FULL_ADDER_4BIT_OVF_EN
            vectors++;
            if (bus.ovf !== exp_o) begin
                miscompares++;
                $display("FAIL sweep_ovf a=%0d b=%0d c=%0d: got %b want %b",
                         ia, ib, ic, bus.ovf, exp_o);
            end
`endif
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.c_in     = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
